// File: rtl/uart_rx_os16.sv
// uart_rx_os16: 16x-oversampling UART receiver.
// Synchronizes rx, qualifies the start bit at mid-bit, shifts DBIT data bits
// in LSB-first, checks the stop bit and presents the word with a one-cycle
// done strobe. All counting advances only on s_tick.
module uart_rx_os16 #(
  parameter int DBIT    = 8,   // data bits per frame (5..9)
  parameter int SB_TICK = 16   // ticks spent in STOP (16/24/32)
) (
  input  logic            clk,
  input  logic            reset,        // async, active low
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err
);

  // Tick counter must reach SB_TICK-1 in STOP; 4 bits covers 0..15 otherwise.
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [SW-1:0] S_MID      = SW'(7);
  localparam logic [SW-1:0] S_BIT_END  = SW'(15);
  localparam logic [SW-1:0] S_STOP_END = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST     = NW'(DBIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            stop_ok_q, stop_ok_d;
  logic            rx_meta_q, rx_meta_d;
  logic            rx_s_q, rx_s_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;
  logic            stop_now;

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;

  // Stop-bit value seen by the frame end; the bypass only matters when the
  // sample tick and the last STOP tick coincide.
  assign stop_now = (s_q == S_MID) ? rx_s_q : stop_ok_q;

  // Next-state logic: synchronizer, receive FSM and registered outputs.
  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    n_d       = n_q;
    b_d       = b_q;
    stop_ok_d = stop_ok_q;
    dout_d    = dout_q;
    ferr_d    = ferr_q;
    done_d    = 1'b0;
    rx_meta_d = rx;
    rx_s_d    = rx_meta_q;

    case (state_q)
      IDLE: begin
        // Falling edge starts a frame; a tick in this cycle is not counted.
        if (!rx_s_q) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_q == S_MID) begin
            if (!rx_s_q) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              // Line went back high before mid-bit: glitch, drop it.
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_q == S_BIT_END) begin
            s_d = '0;
            b_d = {rx_s_q, b_q[DBIT-1:1]};
            if (n_q == N_LAST) state_d = STOP;
            else               n_d     = n_q + NW'(1);
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_q == S_MID) stop_ok_d = rx_s_q;
          if (s_q == S_STOP_END) begin
            state_d = IDLE;
            dout_d  = b_q;
            ferr_d  = ~stop_now;
            done_d  = 1'b1;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; sync flops reset to the idle-high line level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      s_q       <= '0;
      n_q       <= '0;
      b_q       <= '0;
      stop_ok_q <= 1'b0;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      dout_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      b_q       <= b_d;
      stop_ok_q <= stop_ok_d;
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      dout_q    <= dout_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
    end
  end

endmodule

// File: doc/uart_rx_os16.md
# uart_rx_os16

16x-oversampling UART receiver. It consumes the one-cycle `s_tick` strobe from the baud-rate generator, which runs at clock/(16·baud). It synchronizes the serial `rx` line, qualifies the start bit at mid-bit, and shifts in DBIT data bits LSB-first. It checks the stop bit, then presents the byte with a one-cycle done strobe to the downstream FIFO or decoder.

## Interface
- `DBIT`, 8, number of data bits per frame (5..9)
- `SB_TICK`, 16, oversampling ticks spent in stop state (16 = 1 stop bit, 24 = 1.5, 32 = 2)
- `clk`  input  1  system clock; all state on rising edge
- `reset`  input  1  one clock; reset is asynchronous and active-low (0 = reset asserted), deassertion assumed synchronous to `clk`
- `s_tick`  input  1  oversampling strobe, high for one `clk` cycle, 16 per bit period
- `rx`  input  1  asynchronous serial line, idle high
- `dout`  output  DBIT  last received data word
- `rx_done_tick`  output  1  one-cycle pulse: `dout`/`frame_err` updated
- `frame_err`  output  1  stop bit of last frame sampled low

## Operation
- Input sync: `rx` → 2 flip-flops → `rx_s`. Both flip-flops reset to 1. All decisions use `rx_s` only.
- Registers:
  - `state`
  - `s` (4-bit tick counter, wide enough for SB_TICK-1 when SB_TICK>16)
  - `n` (bit counter, ceil(log2(DBIT)) bits)
  - `b` (DBIT shift register)
  - `stop_ok`
- FSM states are IDLE, START, DATA, STOP. Reset state is IDLE.
- IDLE:
  - If `rx_s`==0, go to START and set s=0. No tick is required for this transition.
- START, on `s_tick`:
  - If s==7 and `rx_s`==0: go to DATA, s=0, n=0.
  - If s==7 and `rx_s`==1: false start, return to IDLE, no output.
  - Otherwise s=s+1.
- DATA, on `s_tick`:
  - If s==15: s=0 and b={rx_s, b[DBIT-1:1]} (LSB first). Then, if n==DBIT-1, go to STOP; otherwise n=n+1.
  - Otherwise s=s+1.
- STOP, on `s_tick`:
  - If s==7: stop_ok=`rx_s`.
  - If s==SB_TICK-1: go to IDLE, dout=b, frame_err=~stop_ok, pulse rx_done_tick.
  - Otherwise s=s+1.
- A frame with frame_err=1 still delivers `dout` and still pulses `rx_done_tick`.
- Break condition (rx held low): the frame completes with frame_err=1. IDLE then re-enters START immediately. Each further START check sees `rx_s`=0 and receives another all-zero frame with frame_err=1, until the line returns high.
- Counters in START, DATA and STOP advance only on `s_tick`. Without ticks the FSM holds indefinitely.
- Reset mid-frame: everything returns to IDLE immediately and all outputs clear. Bits received before reset are discarded, and no done pulse is issued.

## Timing
- Reset values: dout=0, rx_done_tick=0, frame_err=0, state=IDLE, s=0, n=0, b=0, stop_ok=0, sync flip-flops=1.
- Input latency: a change on `rx` reaches `rx_s` 2 `clk` cycles later.
- Sampling: start bit checked at tick 8 after the falling edge, at mid-bit. Each data bit is sampled 16 ticks after the previous sample. The stop bit is sampled at tick 8 of STOP.
- Done timing: `rx_done_tick`, `dout` and `frame_err` are registered. All three update in the cycle after the `s_tick` that ends STOP. `rx_done_tick` is high for exactly 1 `clk` cycle per frame.
- Hold: `dout` and `frame_err` stay stable until the next `rx_done_tick`.
- Frame length: 8 + 16·DBIT + SB_TICK ticks from the falling edge to done, which is 152 ticks for defaults, plus 2–3 clk of sync/registration.
- Back-to-back frames: IDLE can detect a new start edge in the cycle after leaving STOP, so a start bit immediately following the stop bit is accepted.
- Tolerance: `s_tick` arriving in the same cycle as the IDLE→START transition is ignored for counting, because s starts at 0 on the next tick.

## Test plan
- Frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB-first), stop=1, s_tick every 4 clk, defaults → exactly one rx_done_tick, dout=0xA5, frame_err=0, done 152 ticks (±1) after the falling edge.
- Start glitch: rx low for 5 ticks then high → FSM returns to IDLE at tick 8, no rx_done_tick, dout keeps previous value.
- Stop bit driven 0 with data 0x3C → rx_done_tick, dout=0x3C, frame_err=1. Next frame 0x81 with good stop → frame_err=0.
- Back-to-back 0x00, 0xFF, 0x55 with no idle gap → three pulses, dout sequence 0x00, 0xFF, 0x55, all frame_err=0.
- Reset asserted (reset=0) at bit 4 of 0xC3, released, then frame 0x12 sent → no pulse for the aborted frame, outputs 0 during reset, then dout=0x12.
- DBIT=7, SB_TICK=32, frame 0x5A → dout=7'h5A, done after 8+112+32=152 ticks; s_tick gated off for 100 clk mid-DATA → FSM holds, result still correct.
